// File: rtl/fpu_pkg.sv
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared opcode/state encodings and constants for the vector
//                FPU issue block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      DIV = 2'b10,
      MUL = 2'b11
   } fpu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      GAP   = 2'b10,
      DONE  = 2'b11
   } fsm_state_e;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

`default_nettype wire

// File: rtl/fpu_vector_issue_if.sv
// ============================================================================
//  Module      : fpu_vector_issue_if
//  Description : Handshake bundle between the vector issue block (master)
//                and the scalar FPU (slave).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fpu_vector_issue_if;
   logic        fpu_enable;
   logic [31:0] fpu_A;
   logic [31:0] fpu_B;
   logic [1:0]  fpu_opcode;
   logic        fpu_ready;
   logic [31:0] fpu_O;

   modport master (
      output fpu_enable, fpu_A, fpu_B, fpu_opcode,
      input  fpu_ready, fpu_O
   );

   modport slave (
      input  fpu_enable, fpu_A, fpu_B, fpu_opcode,
      output fpu_ready, fpu_O
   );
endinterface

`default_nettype wire

// File: rtl/fpu_vector_issue.sv
// ============================================================================
//  Module      : fpu_vector_issue
//  Description : Serialises a LANES-wide vector op onto one scalar FPU, one
//                element at a time, with a one-cycle idle gap between lanes.
//                Optional macro FPU_TIMEOUT_EN adds a per-lane ready timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_vector_issue
   import fpu_pkg::*;
#(
   parameter int LANES          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          opcode,
   input  logic [32*LANES-1:0] VA,
   input  logic [32*LANES-1:0] VB,
   fpu_vector_issue_if.master  fpu,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [32*LANES-1:0] VO
);

   localparam int                 c_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(LANES - 1);

   fsm_state_e          r_state;
   fsm_state_e          w_next;
   logic [c_IDX_W-1:0]  r_idx;
   logic [32*LANES-1:0] r_va;
   logic [32*LANES-1:0] r_vb;
   logic [32*LANES-1:0] r_vo;
   fpu_op_e             r_op;
   logic                w_accept;
   logic                w_timeout;
   logic                w_capture;
   logic [31:0]         w_lane_a;
   logic [31:0]         w_lane_b;

   assign w_accept  = (r_state == IDLE) && start;
   assign w_lane_a  = r_va[32*r_idx +: 32];
   assign w_lane_b  = r_vb[32*r_idx +: 32];
   assign w_capture = (r_state == ISSUE) && (fpu.fpu_ready || w_timeout);

`ifdef FPU_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_CNT_W-1:0] r_tmo_cnt;
   logic               r_error;

   // Fires on the TIMEOUT_CYCLES-th ISSUE cycle of a lane that never saw ready.
   assign w_timeout = (r_state == ISSUE) && !fpu.fpu_ready &&
                      (r_tmo_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_tmo_cnt <= '0;
         r_error   <= 1'b0;
      end else begin
         if ((r_state == ISSUE) && !w_capture)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         else
            r_tmo_cnt <= '0;

         if (w_accept)
            r_error <= 1'b0;
         else if (w_timeout)
            r_error <= 1'b1;
      end
   end

   assign error = r_error;
`else
   assign w_timeout = 1'b0;
   assign error     = 1'b0;
`endif

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      fpu.fpu_enable = 1'b0;
      fpu.fpu_A      = '0;
      fpu.fpu_B      = '0;
      fpu.fpu_opcode = '0;
      case (r_state)
         IDLE: begin
            if (start)
               w_next = ISSUE;
         end
         ISSUE: begin
            fpu.fpu_enable = 1'b1;
            fpu.fpu_A      = w_lane_a;
            fpu.fpu_B      = w_lane_b;
            fpu.fpu_opcode = r_op;
            if (w_capture)
               w_next = (r_idx == c_LAST) ? DONE : GAP;
         end
         GAP:     w_next = ISSUE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_idx <= '0;
         r_va  <= '0;
         r_vb  <= '0;
         r_op  <= ADD;
         r_vo  <= '0;
      end else begin
         if (w_accept) begin
            r_va  <= VA;
            r_vb  <= VB;
            r_op  <= fpu_op_e'(opcode);
            r_idx <= '0;
         end
         if (w_capture)
            r_vo[32*r_idx +: 32] <= w_timeout ? FP_QNAN : fpu.fpu_O;
         if (r_state == GAP)
            r_idx <= r_idx + 1'b1;
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign VO   = r_vo;

endmodule

`default_nettype wire

// File: tb/tb_fpu_vector_issue.sv
// ============================================================================
//  Module      : tb_fpu_vector_issue
//  Description : Directed self-checking bench for fpu_vector_issue with a
//                latency-programmable FPU stub.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_vector_issue;

   localparam int LANES = 4;

   logic                CLK;
   logic                reset;
   logic                start;
   logic [1:0]          opcode;
   logic [32*LANES-1:0] VA;
   logic [32*LANES-1:0] VB;
   logic                busy;
   logic                done;
   logic                error;
   logic [32*LANES-1:0] VO;

   int checks   = 0;
   int failures = 0;
   int lat      = 3;
   bit withhold = 1'b0;
   int mcnt;

   fpu_vector_issue_if bus ();

   fpu_vector_issue #(.LANES(LANES), .TIMEOUT_CYCLES(64)) dut (
      .CLK    (CLK),
      .reset  (reset),
      .start  (start),
      .opcode (opcode),
      .VA     (VA),
      .VB     (VB),
      .fpu    (bus),
      .busy   (busy),
      .done   (done),
      .error  (error),
      .VO     (VO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // FPU stub: ready on the lat-th consecutive enabled cycle; known float
   // cases return hand-computed results, anything else returns A^B.
   function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 2'b00 && a == 32'h4150_0000 && b == 32'h428C_0000) return 32'h42A6_0000;
      if (op == 2'b11 && a == 32'h4170_0000 && b == 32'hC250_0000) return 32'hC443_0000;
      if (op == 2'b10 && a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ b;
   endfunction

   always @(posedge CLK) begin
      if (!bus.fpu_enable) mcnt <= 0;
      else                 mcnt <= mcnt + 1;
   end

   assign bus.fpu_ready = bus.fpu_enable && (mcnt == lat - 1) &&
                          !(withhold && bus.fpu_A == 32'hDEAD_0001);
   assign bus.fpu_O     = model_res(bus.fpu_opcode, bus.fpu_A, bus.fpu_B);

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one op; n = edges after the start-sampling edge until done is seen.
   task automatic run_op(input logic [1:0] op, input logic [127:0] a, input logic [127:0] b,
                         input int k, input int pulse_at, input logic [127:0] alt_a,
                         output int n, output int gaps, output int busy_low,
                         output int en_viol, output logic [127:0] snap);
      lat = k; opcode = op; VA = a; VB = b; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; gaps = 0; busy_low = 0; en_viol = 0; snap = VO;
      if (!busy) busy_low++;
      while (!done && n < 400) begin
         if (n == pulse_at) begin
            start = 1'b1; VA = alt_a; opcode = ~op;
         end
         tick();
         n++;
         start = 1'b0; VA = a; opcode = op;
         if (n == pulse_at + 1) snap = VO;
         if (!busy) busy_low++;
         if (busy && !done && !bus.fpu_enable) gaps++;
         if (!bus.fpu_enable && (bus.fpu_A != 0 || bus.fpu_B != 0 || bus.fpu_opcode != 0)) en_viol++;
      end
   endtask

   initial begin
      int n, gaps, busy_low, en_viol;
      logic [127:0] snap;

      reset = 1'b0; start = 1'b0; opcode = 2'b00; VA = '0; VB = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_vo", VO, 0);
      check("rst_en", bus.fpu_enable, 0);
      check("rst_a", bus.fpu_A, 0);
      reset = 1'b1;
      tick(); tick();
      check("no_start_after_rst", busy, 0);

      // add, k=3: done at edge 15 after start edge, three single-cycle gaps
      run_op(2'b00, {4{32'h4150_0000}}, {4{32'h428C_0000}}, 3, -1, '0, n, gaps, busy_low, en_viol, snap);
      check("add_done_cycle", n, 15);
      check("add_vo", VO, {4{32'h42A6_0000}});
      check("add_gaps", gaps, 3);
      check("add_idle_zero", en_viol, 0);
      check("add_busy", busy_low, 0);
      check("add_error", error, 0);
      tick();
      check("add_done_one_cycle", done, 0);
      check("add_idle_busy", busy, 0);
      check("add_vo_hold", VO, {4{32'h42A6_0000}});

      // mul, k=1: lane 0 real float, other lanes via stub XOR
      run_op(2'b11, {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h4170_0000},
             {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'hC250_0000}, 1, -1, '0,
             n, gaps, busy_low, en_viol, snap);
      check("mul_done_cycle", n, 7);
      check("mul_vo", VO, {32'h0000_0333, 32'h0000_0222, 32'h0000_0111, 32'hC443_0000});
      check("mul_gaps", gaps, 3);
      check("mul_idle_zero", en_viol, 0);
      tick();

      // div, latency 16
      run_op(2'b10, {4{32'h40C0_0000}}, {4{32'h4000_0000}}, 16, -1, '0, n, gaps, busy_low, en_viol, snap);
      check("div_done_cycle", n, 67);
      check("div_vo", VO, {4{32'h4040_0000}});
      check("div_busy", busy_low, 0);
      tick();

      // start during lane 1 ISSUE is ignored; unwritten lanes keep old values
      run_op(2'b00, {4{32'h4150_0000}}, {4{32'h428C_0000}}, 3, 4, {4{32'h1111_1111}},
             n, gaps, busy_low, en_viol, snap);
      check("ign_mid_lane0", snap[31:0], 32'h42A6_0000);
      check("ign_mid_lane3", snap[127:96], 32'h4040_0000);
      check("ign_done_cycle", n, 15);
      check("ign_vo", VO, {4{32'h42A6_0000}});
      tick();
      check("ign_no_restart", busy, 0);

      // asynchronous reset during lane 2 ISSUE
      lat = 3; opcode = 2'b11; VA = {4{32'h4170_0000}}; VB = {4{32'hC250_0000}}; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("mid_en_before_rst", bus.fpu_enable, 1);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_en", bus.fpu_enable, 0);
      check("mid_rst_a", bus.fpu_A, 0);
      check("mid_rst_vo", VO, 0);
      tick();
      reset = 1'b1;
      tick(); tick();
      check("mid_rst_stays_idle", busy, 0);

`ifdef FPU_TIMEOUT_EN
      withhold = 1'b1;
      run_op(2'b00, {32'h0000_0033, 32'h0000_0022, 32'hDEAD_0001, 32'h0000_0011},
             {32'h0000_0300, 32'h0000_0200, 32'h0000_0000, 32'h0000_0100}, 2, -1, '0,
             n, gaps, busy_low, en_viol, snap);
      withhold = 1'b0;
      check("tmo_done_cycle", n, 73);
      check("tmo_vo", VO, {32'h0000_0333, 32'h0000_0222, 32'h7FC0_0000, 32'h0000_0111});
      check("tmo_error", error, 1);
      tick();
      check("tmo_error_sticky", error, 1);
      run_op(2'b00, {4{32'h4150_0000}}, {4{32'h428C_0000}}, 1, -1, '0, n, gaps, busy_low, en_viol, snap);
      check("tmo_error_cleared", error, 0);
      check("tmo_next_vo", VO, {4{32'h42A6_0000}});
`else
      lat = 40;
      run_op(2'b00, {4{32'h4150_0000}}, {4{32'h428C_0000}}, 40, -1, '0, n, gaps, busy_low, en_viol, snap);
      check("long_wait_done_cycle", n, 163);
      check("long_wait_error", error, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
